// File: rtl/hawk_tbl_updt.sv
// hawk_tbl_updt: commits an allocation as an ATT write then a list write over AXI, then advances the free-list head
module hawk_tbl_updt #(
  parameter logic [63:0] ATT_START = 64'h0,
  parameter logic [63:0] LIST_START = 64'h0,
  parameter logic [47:0] HPPA_BASE = 48'h0,
  parameter int LST_IDX_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 head_init_vld_i,
  input  logic [LST_IDX_W-1:0] head_init_i,
  input  logic                 req_vld_i,
  output logic                 req_rdy_o,
  input  logic [47:0]          hppa_i,
  input  logic [47:0]          ppa_i,
  input  logic [LST_IDX_W-1:0] next_head_i,
  output logic [LST_IDX_W-1:0] freeLstHead_o,
  output logic                 awvalid_o,
  input  logic                 awready_i,
  output logic [63:0]          awaddr_o,
  output logic [7:0]           awlen_o,
  output logic [2:0]           awsize_o,
  output logic [1:0]           awburst_o,
  output logic                 wvalid_o,
  input  logic                 wready_i,
  output logic [511:0]         wdata_o,
  output logic [63:0]          wstrb_o,
  output logic                 wlast_o,
  input  logic                 bvalid_i,
  input  logic [1:0]           bresp_i,
  output logic                 bready_o,
  output logic                 done_o,
  output logic                 err_o
);
  typedef enum logic [2:0] {IDLE, ATT_WR, ATT_B, LST_WR, LST_B, DONE} state_t;
  state_t r_state, w_nxt;
  logic [31:0] r_idx;
  logic [LST_IDX_W-1:0] r_next, r_hcap, r_head;
  logic r_awvalid, r_wvalid, r_bready, r_done, r_err;
  logic [63:0] r_awaddr, r_wstrb;
  logic [511:0] r_wdata;
  logic [63:0] w_off, w_hm1;
  logic w_acc, w_wr_done, w_b_ok, w_b_err, w_load;
  assign w_off = {16'b0, hppa_i} - {16'b0, HPPA_BASE};
  assign w_hm1 = 64'(r_hcap) - 64'd1;
  assign w_acc = req_vld_i && r_state == IDLE;
  assign w_wr_done = (!r_awvalid || awready_i) && (!r_wvalid || wready_i);
  assign w_b_ok = r_bready && bvalid_i && bresp_i == 2'b00;
  assign w_b_err = r_bready && bvalid_i && bresp_i != 2'b00;
  assign w_load = w_nxt != r_state && (w_nxt == ATT_WR || w_nxt == LST_WR);
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    w_nxt = w_acc && r_head != '0 ? ATT_WR : IDLE;
      ATT_WR:  w_nxt = w_wr_done ? ATT_B : ATT_WR;
      ATT_B:   w_nxt = w_b_ok ? LST_WR : w_b_err ? IDLE : ATT_B;
      LST_WR:  w_nxt = w_wr_done ? LST_B : LST_WR;
      LST_B:   w_nxt = w_b_ok ? DONE : w_b_err ? IDLE : LST_B;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_nxt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx <= '0;
      r_next <= '0;
      r_hcap <= '0;
      r_head <= '0;
      r_awvalid <= 1'b0;
      r_wvalid <= 1'b0;
      r_bready <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_awaddr <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= r_state == LST_B && w_b_ok;
      r_err <= (w_acc && r_head == '0) || w_b_err;
      r_bready <= w_nxt == ATT_B || w_nxt == LST_B;
      r_awvalid <= w_load || (r_awvalid && !awready_i);
      r_wvalid <= w_load || (r_wvalid && !wready_i);
      r_head <= head_init_vld_i ? head_init_i : r_state == LST_B && w_b_ok ? r_next : r_head;
      if (w_acc) begin
        r_idx <= w_off[31:0];
        r_next <= next_head_i;
        r_hcap <= r_head;
      end
      if (w_load) begin
        r_awaddr <= r_state == IDLE ? ATT_START + ((w_off >> 3) << 6) : LIST_START + ((w_hm1 >> 2) << 6);
        r_wstrb <= r_state == IDLE ? 64'hFF << {w_off[2:0], 3'b0} : 64'hFFFF << {w_hm1[1:0], 4'b0};
        r_wdata <= r_state == IDLE ? {448'b0, 2'b01, 14'b0, ppa_i} << {w_off[2:0], 6'b0}
                                   : {384'b0, 32'b0, r_idx, 64'b0} << {w_hm1[1:0], 7'b0};
      end
    end
  end
  assign req_rdy_o = r_state == IDLE;
  assign freeLstHead_o = r_head;
  assign awvalid_o = r_awvalid;
  assign awaddr_o = r_awaddr;
  assign awlen_o = 8'd0;
  assign awsize_o = 3'd6;
  assign awburst_o = 2'b01;
  assign wvalid_o = r_wvalid;
  assign wdata_o = r_wdata;
  assign wstrb_o = r_wstrb;
  assign wlast_o = 1'b1;
  assign bready_o = r_bready;
  assign done_o = r_done;
  assign err_o = r_err;
endmodule

// File: tb/tb_hawk_tbl_updt.sv
// tb_hawk_tbl_updt: vector table with an AXI slave model and a write scoreboard for hawk_tbl_updt
module tb_hawk_tbl_updt;
  localparam logic [63:0] ATT_S = 64'h1000_0000;
  localparam logic [63:0] LST_S = 64'h2000_0000;
  localparam logic [47:0] HBASE = 48'h100;
  typedef struct {
    logic ld;
    logic [31:0] head;
    logic [63:0] off;
    logic [47:0] ppa;
    logic [31:0] nxt;
    logic [1:0] bresp;
    int aw_dly;
    int w_dly;
    int init_at;
    logic [31:0] init_val;
    logic exp_done;
    int exp_lat;
    logic [31:0] exp_head;
    int exp_awv;
    int exp_wv;
    int exp_b;
    logic [63:0] att_addr;
    logic [63:0] lst_addr;
  } vec_t;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic head_init_vld_i = 1'b0, req_vld_i = 1'b0;
  logic [31:0] head_init_i = '0, next_head_i = '0;
  logic [47:0] hppa_i = '0, ppa_i = '0;
  logic req_rdy_o, awvalid_o, wvalid_o, wlast_o, bready_o, done_o, err_o;
  logic awready_i, wready_i, bvalid_i;
  logic [1:0] bresp_i, awburst_o;
  logic [31:0] freeLstHead_o;
  logic [63:0] awaddr_o, wstrb_o;
  logic [7:0] awlen_o;
  logic [2:0] awsize_o;
  logic [511:0] wdata_o;
  int total = 0, bad = 0;
  int aw_dly = 0, w_dly = 0, aw_wait = 0, w_wait = 0;
  int n_awv = 0, n_wv = 0, n_b = 0;
  logic [1:0] g_bresp = 2'b00;
  logic [63:0] exp_aw[$];
  logic [575:0] exp_w[$];
  logic [63:0] m_aw, p_awaddr;
  logic [575:0] m_w, p_w;
  logic p_aw_hold = 1'b0, p_w_hold = 1'b0;
  vec_t vecs[10];
  vec_t rv;
  hawk_tbl_updt #(.ATT_START(ATT_S), .LIST_START(LST_S), .HPPA_BASE(HBASE), .LST_IDX_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .head_init_vld_i(head_init_vld_i), .head_init_i(head_init_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .hppa_i(hppa_i), .ppa_i(ppa_i),
    .next_head_i(next_head_i), .freeLstHead_o(freeLstHead_o), .awvalid_o(awvalid_o),
    .awready_i(awready_i), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .wlast_o(wlast_o), .bvalid_i(bvalid_i), .bresp_i(bresp_i),
    .bready_o(bready_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic push_att(input vec_t v);
    logic [511:0] d;
    d = {448'b0, 2'b01, 14'b0, v.ppa} << (64 * v.off[2:0]);
    exp_aw.push_back(v.att_addr);
    exp_w.push_back({64'hFF << (8 * v.off[2:0]), d});
  endtask
  task automatic push_lst(input vec_t v);
    logic [511:0] d;
    logic [31:0] hm;
    hm = v.head - 32'd1;
    d = {384'b0, 32'b0, v.off[31:0], 64'b0} << (128 * hm[1:0]);
    exp_aw.push_back(v.lst_addr);
    exp_w.push_back({64'hFFFF << (16 * hm[1:0]), d});
  endtask
  initial begin
    awready_i = 1'b0;
    wready_i = 1'b0;
    bvalid_i = 1'b1;
    bresp_i = 2'b00;
    forever begin
      @(posedge clk_i);
      #1;
      aw_wait = awvalid_o ? aw_wait + 1 : 0;
      w_wait = wvalid_o ? w_wait + 1 : 0;
      awready_i = awvalid_o && aw_wait > aw_dly;
      wready_i = wvalid_o && w_wait > w_dly;
      bresp_i = g_bresp;
    end
  end
  always @(negedge clk_i) begin
    if (awvalid_o) n_awv++;
    if (wvalid_o) n_wv++;
    if (bvalid_i && bready_o) n_b++;
    if (rst_ni && p_aw_hold) chk("aw_hold", 576'({awvalid_o, awaddr_o}), 576'({1'b1, p_awaddr}));
    if (rst_ni && p_w_hold) chk("w_hold", 576'({wvalid_o, wstrb_o, wdata_o}), {1'b1, p_w});
    if (awvalid_o && awready_i) begin
      if (exp_aw.size() == 0) begin
        total++;
        bad++;
        $display("FAIL aw_extra: got addr %0h with no write expected", awaddr_o);
      end else begin
        m_aw = exp_aw.pop_front();
        chk("awaddr", 576'(awaddr_o), 576'(m_aw));
      end
      chk("aw_attr", 576'({awlen_o, awsize_o, awburst_o}), 576'({8'd0, 3'd6, 2'b01}));
    end
    if (wvalid_o && wready_i) begin
      if (exp_w.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w_extra: got strb %0h with no write expected", wstrb_o);
      end else begin
        m_w = exp_w.pop_front();
        chk("wbeat", {wstrb_o, wdata_o}, m_w);
      end
      chk("wlast", 576'(wlast_o), 576'(1'b1));
    end
    p_aw_hold = awvalid_o && !awready_i;
    p_awaddr = awaddr_o;
    p_w_hold = wvalid_o && !wready_i;
    p_w = {wstrb_o, wdata_o};
  end
  task automatic run(input vec_t v, input string nm);
    int lat;
    logic gd, ge;
    @(posedge clk_i);
    #1;
    aw_dly = v.aw_dly;
    w_dly = v.w_dly;
    g_bresp = v.bresp;
    if (v.ld) begin
      head_init_vld_i = 1'b1;
      head_init_i = v.head;
      @(posedge clk_i);
      #1;
      head_init_vld_i = 1'b0;
    end
    chk({nm, "_rdy"}, 576'(req_rdy_o), 576'(1'b1));
    n_awv = 0;
    n_wv = 0;
    n_b = 0;
    if (v.exp_b > 0) push_att(v);
    if (v.exp_b > 1) push_lst(v);
    req_vld_i = 1'b1;
    hppa_i = HBASE + v.off[47:0];
    ppa_i = v.ppa;
    next_head_i = v.nxt;
    @(posedge clk_i);
    #1;
    req_vld_i = 1'b0;
    lat = 0;
    gd = 1'b0;
    ge = 1'b0;
    for (int c = 1; c <= 80 && lat == 0; c++) begin
      head_init_vld_i = c == v.init_at;
      head_init_i = v.init_val;
      @(negedge clk_i);
      if (done_o || err_o) begin
        lat = c;
        gd = done_o;
        ge = err_o;
      end else begin
        @(posedge clk_i);
        #1;
      end
    end
    head_init_vld_i = 1'b0;
    chk({nm, "_lat"}, 576'(lat), 576'(v.exp_lat));
    chk({nm, "_done_err"}, 576'({gd, ge}), 576'({v.exp_done, !v.exp_done}));
    chk({nm, "_head"}, 576'(freeLstHead_o), 576'(v.exp_head));
    chk({nm, "_rdy_end"}, 576'(req_rdy_o), 576'(!v.exp_done));
    chk({nm, "_awv_cyc"}, 576'(n_awv), 576'(v.exp_awv));
    chk({nm, "_wv_cyc"}, 576'(n_wv), 576'(v.exp_wv));
    chk({nm, "_b_cnt"}, 576'(n_b), 576'(v.exp_b));
    chk({nm, "_left"}, 576'({exp_aw.size(), exp_w.size()}), 576'(0));
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{1'b1, 32'd5, 64'd10, 48'h1234, 32'd6, 2'b00, 0, 0, 0, 32'd0, 1'b1, 5, 32'd6, 2, 2, 2, 64'h1000_0040, 64'h2000_0040};
    vecs[1] = '{1'b1, 32'd4, 64'd7, 48'hABCDEF012345, 32'd9, 2'b00, 3, 0, 0, 32'd0, 1'b1, 11, 32'd9, 8, 2, 2, 64'h1000_0000, 64'h2000_0000};
    vecs[2] = '{1'b1, 32'd8, 64'h40, 48'h000F_FFFF_FFFF, 32'd2, 2'b00, 0, 2, 0, 32'd0, 1'b1, 9, 32'd2, 2, 6, 2, 64'h1000_0200, 64'h2000_0040};
    vecs[3] = '{1'b1, 32'd5, 64'd3, 48'h55, 32'd6, 2'b10, 0, 0, 0, 32'd0, 1'b0, 3, 32'd5, 1, 1, 1, 64'h1000_0000, 64'h0};
    vecs[4] = '{1'b1, 32'd0, 64'd3, 48'h55, 32'd6, 2'b00, 0, 0, 0, 32'd0, 1'b0, 1, 32'd0, 0, 0, 0, 64'h0, 64'h0};
    vecs[5] = '{1'b1, 32'd1, 64'h13, 48'h777, 32'd0, 2'b00, 0, 0, 0, 32'd0, 1'b1, 5, 32'd0, 2, 2, 2, 64'h1000_0080, 64'h2000_0000};
    vecs[6] = '{1'b0, 32'd0, 64'd4, 48'h88, 32'd3, 2'b00, 0, 0, 0, 32'd0, 1'b0, 1, 32'd0, 0, 0, 0, 64'h0, 64'h0};
    vecs[7] = '{1'b1, 32'd2, 64'd9, 48'h42, 32'd7, 2'b00, 0, 0, 4, 32'd11, 1'b1, 5, 32'd11, 2, 2, 2, 64'h1000_0040, 64'h2000_0000};
    vecs[8] = '{1'b1, 32'h10, 64'h1_0000_0005, 48'h321, 32'h11, 2'b00, 0, 0, 0, 32'd0, 1'b1, 5, 32'h11, 2, 2, 2, 64'h8_1000_0000, 64'h2000_00C0};
    vecs[9] = '{1'b1, 32'd2, 64'h20, 48'hBEEF, 32'd3, 2'b00, 0, 0, 0, 32'd0, 1'b1, 5, 32'd3, 2, 2, 2, 64'h1000_0100, 64'h2000_0000};
    rv = '{1'b1, 32'd3, 64'd2, 48'h99, 32'd4, 2'b00, 20, 0, 0, 32'd0, 1'b1, 0, 32'd4, 0, 0, 2, 64'h1000_0000, 64'h2000_0000};
    repeat (3) @(negedge clk_i);
    chk("reset_ctl", 576'({req_rdy_o, awvalid_o, wvalid_o, bready_o, done_o, err_o}), 576'(6'b100000));
    chk("reset_head", 576'(freeLstHead_o), 576'(0));
    chk("reset_bus", {wstrb_o, wdata_o}, 576'(0));
    chk("reset_addr", 576'(awaddr_o), 576'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 9; i++) run(vecs[i], $sformatf("vec%0d", i));
    @(posedge clk_i);
    #1;
    aw_dly = rv.aw_dly;
    w_dly = rv.w_dly;
    g_bresp = rv.bresp;
    head_init_vld_i = 1'b1;
    head_init_i = rv.head;
    @(posedge clk_i);
    #1;
    head_init_vld_i = 1'b0;
    push_att(rv);
    push_lst(rv);
    req_vld_i = 1'b1;
    hppa_i = HBASE + rv.off[47:0];
    ppa_i = rv.ppa;
    next_head_i = rv.nxt;
    @(posedge clk_i);
    #1;
    req_vld_i = 1'b0;
    repeat (29) begin
      @(posedge clk_i);
      #1;
    end
    chk("rst_pre_awv", 576'({awvalid_o, wvalid_o}), 576'(2'b10));
    chk("rst_pre_q", 576'({exp_aw.size(), exp_w.size()}), 576'({32'd1, 32'd0}));
    rst_ni = 1'b0;
    #1;
    chk("rst_ctl", 576'({req_rdy_o, awvalid_o, wvalid_o, bready_o, done_o, err_o}), 576'(6'b100000));
    chk("rst_head", 576'(freeLstHead_o), 576'(0));
    chk("rst_bus", {wstrb_o, wdata_o}, 576'(0));
    chk("rst_addr", 576'(awaddr_o), 576'(0));
    exp_aw.delete();
    exp_w.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    run(vecs[9], "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
